// File: rtl/i2c_master_burst.sv
// i2c_master_burst: single-master I2C controller running START, address + R/W,
// a burst of len data bytes and STOP, with clock stretching and NACK reporting.
// Ports:
//   clk, reset (async, active-high)
//   start/rd/periph_addr/len : transaction request, latched in IDLE
//   tx_data/tx_valid/tx_ready: write byte stream (tx_ready pulses on latch)
//   rx_data/rx_valid         : read byte output with 1-cycle strobe
//   busy/done/nack           : status (nack sticky until next accepted start)
//   scl_oe/scl_i, sda_oe/sda_i: open-drain pad controls (oe=1 pulls low) and sensed levels
module i2c_master_burst #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LEN_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rd,
    input  logic [6:0]       periph_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             nack,
    output logic             scl_oe,
    input  logic             scl_i,
    output logic             sda_oe,
    input  logic             sda_i
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic             wait_q, wait_d;
    logic             sda_s_q, sda_s_d;
    logic             busy_d, nack_d, done_d, tx_ready_d, rx_valid_d;
    logic [7:0]       rx_data_d;
    logic             scl_oe_d, sda_oe_d;
    logic             hold, tick, bit_end, sample, enter_wr;

    // Stretch hold: freeze at P2 entry while a peripheral keeps SCL low.
    assign hold    = (state_q != IDLE) && (phase_q == 2'd2) && (div_q == '0)
                     && !scl_oe && !scl_i;
    assign tick    = (div_q == DIV_LAST) && !hold && !wait_q;
    assign bit_end = tick && (phase_q == 2'd3);
    assign sample  = tick && (phase_q == 2'd2);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            wait_q   <= 1'b0;
            sda_s_q  <= 1'b1;
            busy     <= 1'b0;
            nack     <= 1'b0;
            done     <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wait_q   <= wait_d;
            sda_s_q  <= sda_s_d;
            busy     <= busy_d;
            nack     <= nack_d;
            done     <= done_d;
            tx_ready <= tx_ready_d;
            rx_valid <= rx_valid_d;
            rx_data  <= rx_data_d;
            scl_oe   <= scl_oe_d;
            sda_oe   <= sda_oe_d;
        end
    end

    // Next-state, bit timing and datapath.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wait_d     = wait_q;
        sda_s_d    = sda_s_q;
        busy_d     = busy;
        nack_d     = nack;
        rx_data_d  = rx_data;
        done_d     = 1'b0;
        tx_ready_d = 1'b0;
        rx_valid_d = 1'b0;
        enter_wr   = 1'b0;

        // Quarter-bit divider; phase wraps 3->0 at each bit boundary.
        if (state_q != IDLE && !hold && !wait_q) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        if (sample) sda_s_d = sda_i;

        case (state_q)
            IDLE: begin
                div_d   = '0;
                phase_d = '0;
                bit_d   = '0;
                wait_d  = 1'b0;
                if (start) begin
                    rd_d    = rd;
                    shift_d = {periph_addr, rd};
                    cnt_d   = len;
                    nack_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bit_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ADDR_ACK;
                end
            end
            ADDR_ACK: begin
                if (bit_end) begin
                    if (sda_s_q) begin
                        nack_d  = 1'b1;
                        state_d = STOP;
                    end else if (cnt_q == '0) begin
                        state_d = STOP;
                    end else if (rd_q) begin
                        bit_d   = '0;
                        state_d = RD_BYTE;
                    end else begin
                        enter_wr = 1'b1;
                    end
                end
            end
            WR_BYTE: begin
                if (wait_q && tx_valid) begin
                    shift_d    = tx_data;
                    tx_ready_d = 1'b1;
                    wait_d     = 1'b0;
                end
                if (bit_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - LEN_W'(1);
                        state_d = WR_ACK;
                    end
                end
            end
            WR_ACK: begin
                if (bit_end) begin
                    if (sda_s_q) begin
                        nack_d  = 1'b1;
                        state_d = STOP;
                    end else if (cnt_q != '0) begin
                        enter_wr = 1'b1;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            RD_BYTE: begin
                if (sample) shift_d = {shift_q[6:0], sda_i};
                // Strobe lands on the last clock of bit 7's P3.
                if (bit_q == 3'd7 && phase_d == 2'd3 && div_d == DIV_LAST) begin
                    rx_data_d  = shift_d;
                    rx_valid_d = 1'b1;
                end
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - LEN_W'(1);
                        state_d = RD_ACK;
                    end
                end
            end
            RD_ACK: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = (cnt_q != '0) ? RD_BYTE : STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Byte fetch: latch now if offered, otherwise stall in P0 with SCL low.
        if (enter_wr) begin
            state_d = WR_BYTE;
            bit_d   = '0;
            if (tx_valid) begin
                shift_d    = tx_data;
                tx_ready_d = 1'b1;
                wait_d     = 1'b0;
            end else begin
                wait_d = 1'b1;
            end
        end
    end

    // Pad drive derived from the upcoming state so the pins are registered.
    always_comb begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        if (state_d != IDLE && state_d != START) scl_oe_d = !phase_d[1];
        case (state_d)
            START:   sda_oe_d = phase_d[1];
            ADDR:    sda_oe_d = !shift_d[7];
            WR_BYTE: sda_oe_d = !wait_d && !shift_d[7];
            RD_ACK:  sda_oe_d = (cnt_d != '0);
            STOP:    sda_oe_d = (phase_d != 2'd3);
            default: sda_oe_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_i2c_master_burst.sv
// Directed bench for i2c_master_burst (CLK_DIV=2) with a bus-level peripheral model.
module tb_i2c_master_burst;

    logic       clk, reset, start, rd;
    logic [6:0] periph_addr;
    logic [3:0] len;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, busy, done, nack;
    logic       scl_oe, scl_i, sda_oe, sda_i;
    logic       stretch, sl_low;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int lat;

    i2c_master_burst #(.CLK_DIV(2), .LEN_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .rd(rd),
        .periph_addr(periph_addr), .len(len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .done(done), .nack(nack),
        .scl_oe(scl_oe), .scl_i(scl_i), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    // Open-drain wired lines.
    assign scl_i = ~scl_oe & ~stretch;
    assign sda_i = ~sda_oe & ~sl_low;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Write-byte source and read-byte sink.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] tmp;
    int n_txr = 0;
    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (tx_ready) begin
                n_txr++;
                if (txq.size() > 0) tmp = txq.pop_front();
            end
            if (rx_valid) rxq.push_back(rx_data);
            tx_valid = (txq.size() > 0);
            tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
        end
    end

    // Peripheral model: decodes START/STOP/bits from the wires, ACKs and serves reads.
    logic       prev_scl = 1'b1, prev_sda = 1'b1, scl_now, sda_now;
    logic       started = 1'b0, in_addr = 1'b0, is_read = 1'b0;
    logic       have_rise = 1'b0, rise_sda = 1'b1;
    logic       ack_addr = 1'b1, ack_wr = 1'b1;
    logic [7:0] shreg = 8'h00, cur = 8'hFF;
    logic [7:0] seen[$];
    logic [7:0] rdq[$];
    logic       mack[$];
    int bitn = 0, nstop = 0, hold_err = 0, acks_done = 0;
    initial begin
        sl_low = 1'b0;
        forever begin
            @(negedge clk);
            scl_now = scl_i;
            sda_now = sda_i;
            if (prev_scl && scl_now && prev_sda && !sda_now) begin
                started = 1'b1; bitn = 0; in_addr = 1'b1; sl_low = 1'b0; have_rise = 1'b0;
            end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
                started = 1'b0; nstop++; sl_low = 1'b0; have_rise = 1'b0;
            end else if (!prev_scl && scl_now) begin
                rise_sda = sda_now; have_rise = 1'b1;
                if (started) begin
                    if (bitn < 8) shreg = {shreg[6:0], sda_now};
                    else if (is_read && !in_addr) mack.push_back(sda_now);
                    bitn++;
                end
            end else if (prev_scl && !scl_now) begin
                if (have_rise && prev_sda !== rise_sda) hold_err++;
                have_rise = 1'b0;
                if (started) begin
                    if (bitn == 8) begin
                        seen.push_back(shreg);
                        if (in_addr) begin
                            is_read = shreg[0];
                            sl_low  = ack_addr;
                        end else begin
                            sl_low = is_read ? 1'b0 : ack_wr;
                        end
                    end else if (bitn == 9) begin
                        bitn = 0;
                        acks_done++;
                        if (is_read && (in_addr ? ack_addr : (mack.size() > 0 && mack[$] == 1'b0))) begin
                            cur    = (rdq.size() > 0) ? rdq.pop_front() : 8'hFF;
                            sl_low = ~cur[7];
                        end else begin
                            sl_low = 1'b0;
                        end
                        in_addr = 1'b0;
                    end else if (bitn >= 1 && bitn <= 7 && is_read && !in_addr) begin
                        sl_low = ~cur[7-bitn];
                    end
                end
            end else if (prev_scl && scl_now && have_rise && sda_now !== rise_sda) begin
                hold_err++;
            end
            prev_scl = scl_now;
            prev_sda = sda_now;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one clock; returns #1 after the acceptance edge.
    task automatic launch(input logic r, input logic [6:0] a, input logic [3:0] l);
        @(posedge clk);
        #1;
        rd = r; periph_addr = a; len = l; start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk);
            #1;
        end
        lat = cyc - t0;
        check({tag, "_done_seen"}, done, 1'b1);
    endtask

    int falls, low_err, nstop0;
    logic prev_oe;

    initial begin
        reset = 1'b1; start = 1'b0; rd = 1'b0; periph_addr = '0; len = '0; stretch = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {scl_oe, sda_oe, tx_ready, rx_valid, rx_data, busy, done, nack}, 15'h0);
        reset = 1'b0;

        // Write len=1 to 0x48 with a start retried mid-transaction.
        seen.delete(); n_txr = 0; nstop0 = nstop;
        txq.push_back(8'hA5);
        launch(1'b0, 7'h48, 4'd1);
        check("wr1_busy", busy, 1'b1);
        periph_addr = 7'h11; rd = 1'b1; len = 4'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("wr1");
        check("wr1_latency", lat, 161);
        check("wr1_busy_at_done", busy, 1'b0);
        check("wr1_nbytes", seen.size(), 2);
        check("wr1_addr_byte", seen[0], 8'h90);
        check("wr1_data_byte", seen[1], 8'hA5);
        check("wr1_tx_ready_cnt", n_txr, 1);
        check("wr1_nack", nack, 1'b0);
        check("wr1_stop", nstop - nstop0, 1);
        @(posedge clk);
        #1;
        check("wr1_done_pulse", done, 1'b0);

        // Read len=3 from 0x2A.
        seen.delete(); rxq.delete(); mack.delete(); nstop0 = nstop;
        rdq.push_back(8'h12); rdq.push_back(8'h34); rdq.push_back(8'h56);
        launch(1'b1, 7'h2A, 4'd3);
        wait_done("rd3");
        check("rd3_latency", lat, 305);
        check("rd3_addr_byte", seen[0], 8'h55);
        check("rd3_rx_count", rxq.size(), 3);
        check("rd3_rx0", rxq[0], 8'h12);
        check("rd3_rx1", rxq[1], 8'h34);
        check("rd3_rx2", rxq[2], 8'h56);
        check("rd3_master_acks", {mack[0], mack[1], mack[2]}, 3'b001);
        check("rd3_stop", nstop - nstop0, 1);
        check("rd3_nack", nack, 1'b0);

        // Address NACK: STOP right after the address; queued byte untouched.
        seen.delete(); n_txr = 0; nstop0 = nstop; ack_addr = 1'b0;
        txq.push_back(8'h3C);
        launch(1'b0, 7'h7F, 4'd2);
        wait_done("anack");
        check("anack_latency", lat, 89);
        check("anack_nack", nack, 1'b1);
        check("anack_addr_byte", seen[0], 8'hFE);
        check("anack_no_tx_ready", n_txr, 0);
        check("anack_stop", nstop - nstop0, 1);
        txq.delete(); ack_addr = 1'b1;

        // Clock stretch of 37 clocks at data bit 3 (13th SCL release).
        seen.delete(); hold_err = 0;
        txq.push_back(8'hA5);
        launch(1'b0, 7'h48, 4'd1);
        check("str_nack_cleared", nack, 1'b0);
        falls = 0; prev_oe = scl_oe;
        for (int i = 0; i < 400 && falls < 13; i++) begin
            @(posedge clk);
            #1;
            if (prev_oe && !scl_oe) falls++;
            prev_oe = scl_oe;
        end
        check("str_found_bit", falls, 13);
        stretch = 1'b1;
        repeat (37) @(posedge clk);
        #1;
        stretch = 1'b0;
        wait_done("str");
        check("str_latency", lat, 198);
        check("str_addr_byte", seen[0], 8'h90);
        check("str_data_byte", seen[1], 8'hA5);
        check("str_sda_stable", hold_err, 0);

        // Write underflow: byte 2 withheld for 50 clocks.
        seen.delete(); n_txr = 0; acks_done = 0; low_err = 0;
        txq.push_back(8'hC3);
        launch(1'b0, 7'h30, 4'd2);
        for (int i = 0; i < 400 && acks_done < 2; i++) begin
            @(posedge clk);
            #1;
        end
        check("uf_reached_stall", acks_done, 2);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (!scl_oe || tx_valid) low_err++;
        end
        check("uf_scl_held_low", low_err, 0);
        txq.push_back(8'h5A);
        wait_done("uf");
        check("uf_addr_byte", seen[0], 8'h60);
        check("uf_byte1", seen[1], 8'hC3);
        check("uf_byte2", seen[2], 8'h5A);
        check("uf_tx_ready_cnt", n_txr, 2);
        check("uf_nack", nack, 1'b0);

        // Reset in address bit 2 (a 0 bit, P1), then an address-only probe.
        txq.push_back(8'h77);
        launch(1'b0, 7'h48, 4'd1);
        repeat (26) @(posedge clk);
        #1;
        check("rst_pre_lines", {scl_oe, sda_oe}, 2'b11);
        nstop0 = nstop;
        #2;
        reset = 1'b1;
        #1;
        check("rst_lines_released", {scl_oe, sda_oe, busy}, 3'b000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        txq.delete();
        repeat (4) @(posedge clk);
        #1;
        check("rst_no_stop", nstop - nstop0, 0);
        seen.delete(); nstop0 = nstop;
        launch(1'b0, 7'h48, 4'd0);
        wait_done("probe");
        check("probe_latency", lat, 89);
        check("probe_addr_byte", seen[0], 8'h90);
        check("probe_nack", nack, 1'b0);
        check("probe_stop", nstop - nstop0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
